// File: rtl/rv_decode_pkg.sv
// Shared types for the RV32 decode stage: instruction views, decoded bundle, formats, opcodes.
package rv_decode_pkg;

  typedef logic [4:0] reg_addr_t;
  typedef logic [6:0] opcode_t;

  typedef struct packed {
    logic [6:0] func7;
    reg_addr_t  rs2;
    reg_addr_t  rs1;
    logic [2:0] func3;
    reg_addr_t  rd;
    opcode_t    opcode;
  } R_t;

  typedef struct packed {
    logic [11:0] imm;
    reg_addr_t   rs1;
    logic [2:0]  func3;
    reg_addr_t   rd;
    opcode_t     opcode;
  } I_t;

  typedef struct packed {
    logic [19:0] imm;
    reg_addr_t   rd;
    opcode_t     opcode;
  } U_t;

  typedef union packed {
    R_t r;
    I_t i;
    U_t u;
  } instruction_t;

  typedef enum logic [1:0] {
    FMT_R = 2'd0,
    FMT_I = 2'd1,
    FMT_U = 2'd2,
    FMT_X = 2'd3
  } fmt_t;

  typedef enum logic [1:0] {
    BUF_EMPTY,
    BUF_ONE,
    BUF_TWO
  } buf_state_t;

  localparam opcode_t OPC_OP     = 7'b0110011;
  localparam opcode_t OPC_OP_IMM = 7'b0010011;
  localparam opcode_t OPC_LOAD   = 7'b0000011;
  localparam opcode_t OPC_JALR   = 7'b1100111;
  localparam opcode_t OPC_LUI    = 7'b0110111;
  localparam opcode_t OPC_AUIPC  = 7'b0010111;

  typedef struct packed {
    opcode_t     opcode;
    reg_addr_t   rd;
    reg_addr_t   rs1;
    reg_addr_t   rs2;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [31:0] imm;
    fmt_t        fmt;
    logic        illegal;
  } decoded_t;

  function automatic fmt_t fmt_of(input opcode_t op);
    case (op)
      OPC_OP:                       return FMT_R;
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: return FMT_I;
      OPC_LUI, OPC_AUIPC:           return FMT_U;
      default:                      return FMT_X;
    endcase
  endfunction

endpackage

// File: rtl/rv_decode_stage_if.sv
// Fetch-to-decode input and decode-to-execute output handshakes of the decode stage.
interface rv_decode_stage_if
  import rv_decode_pkg::*;
#(
  parameter int PC_W = 32
) ();

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  logic [PC_W-1:0] out_pc;
  logic [6:0]      out_opcode;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [2:0]      out_func3;
  logic [6:0]      out_func7;
  logic [31:0]     out_imm;
  fmt_t            out_fmt;
  logic            out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
           out_func3, out_func7, out_imm, out_fmt, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
           out_func3, out_func7, out_imm, out_fmt, out_illegal
  );

endinterface

// File: rtl/rv_decode_fields.sv
// Combinational field extraction: instruction_t -> decoded_t (format, immediate, illegal flag).
module rv_decode_fields
  import rv_decode_pkg::*;
(
  input  instruction_t instr,
  output decoded_t     dec
);

  always_comb begin
    dec        = '0;
    dec.opcode = instr.r.opcode;
    dec.fmt    = fmt_of(instr.r.opcode);
    case (dec.fmt)
      FMT_R: begin
        dec.rd    = instr.r.rd;
        dec.rs1   = instr.r.rs1;
        dec.rs2   = instr.r.rs2;
        dec.func3 = instr.r.func3;
        dec.func7 = instr.r.func7;
      end
      FMT_I: begin
        dec.rd    = instr.i.rd;
        dec.rs1   = instr.i.rs1;
        dec.func3 = instr.i.func3;
        dec.imm   = {{20{instr.i.imm[11]}}, instr.i.imm};
      end
      FMT_U: begin
        dec.rd  = instr.u.rd;
        dec.rs1 = instr.r.rs1;
        dec.imm = {instr.u.imm, 12'h000};
      end
      default: begin
        // Unsupported opcodes keep only opcode/pc so execute can trap on them.
        dec.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/rv_decode_stage.sv
// RV32 decode stage: 1-cycle latency, 1 instr/cycle; 2-entry elastic buffer keeps in_ready registered.
// Optional RV_DECODE_STATS_EN adds saturating handshake/illegal counters.
module rv_decode_stage
  import rv_decode_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  rv_decode_stage_if.slave  bus
`ifdef RV_DECODE_STATS_EN
  ,
  output logic [15:0]       stat_count,
  output logic [15:0]       stat_illegal
`endif
);

  decoded_t        in_dec;
  decoded_t        out_dec;
  decoded_t        skid_dec;
  logic [PC_W-1:0] out_pc_q;
  logic [PC_W-1:0] skid_pc;
  buf_state_t      state;
  buf_state_t      state_n;
  logic            rst_q;
  logic            ld_out;
  logic            out_from_skid;
  logic            ld_skid;
  logic            in_fire;
  logic            out_fire;

  rv_decode_fields u_fields (
    .instr (bus.in_instr),
    .dec   (in_dec)
  );

  // rst_q holds in_ready low for the first cycle after reset releases.
  assign bus.in_ready  = (state != BUF_TWO) && !rst_q;
  assign bus.out_valid = (state != BUF_EMPTY);
  assign in_fire       = bus.in_valid && bus.in_ready;
  assign out_fire      = bus.out_valid && bus.out_ready;

  always_comb begin
    state_n       = state;
    ld_out        = 1'b0;
    out_from_skid = 1'b0;
    ld_skid       = 1'b0;
    case (state)
      BUF_EMPTY: begin
        if (in_fire) begin
          ld_out  = 1'b1;
          state_n = BUF_ONE;
        end
      end
      BUF_ONE: begin
        if (in_fire && bus.out_ready) begin
          ld_out = 1'b1;
        end else if (in_fire) begin
          ld_skid = 1'b1;
          state_n = BUF_TWO;
        end else if (bus.out_ready) begin
          state_n = BUF_EMPTY;
        end
      end
      BUF_TWO: begin
        if (bus.out_ready) begin
          ld_out        = 1'b1;
          out_from_skid = 1'b1;
          state_n       = BUF_ONE;
        end
      end
      default: state_n = BUF_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst) begin
      state    <= BUF_EMPTY;
      out_dec  <= '0;
      out_pc_q <= '0;
      skid_dec <= '0;
      skid_pc  <= '0;
    end else begin
      state <= state_n;
      if (ld_out) begin
        out_dec  <= out_from_skid ? skid_dec : in_dec;
        out_pc_q <= out_from_skid ? skid_pc : bus.in_pc;
      end
      if (ld_skid) begin
        skid_dec <= in_dec;
        skid_pc  <= bus.in_pc;
      end
    end
  end

  assign bus.out_pc      = out_pc_q;
  assign bus.out_opcode  = out_dec.opcode;
  assign bus.out_rd      = out_dec.rd;
  assign bus.out_rs1     = out_dec.rs1;
  assign bus.out_rs2     = out_dec.rs2;
  assign bus.out_func3   = out_dec.func3;
  assign bus.out_func7   = out_dec.func7;
  assign bus.out_imm     = out_dec.imm;
  assign bus.out_fmt     = out_dec.fmt;
  assign bus.out_illegal = out_dec.illegal;

`ifdef RV_DECODE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_count   <= '0;
      stat_illegal <= '0;
    end else if (out_fire) begin
      if (stat_count != 16'hFFFF) stat_count <= stat_count + 16'd1;
      if (out_dec.illegal && stat_illegal != 16'hFFFF) stat_illegal <= stat_illegal + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rv_decode_stage.sv
// Directed bench for rv_decode_stage: scoreboard of expected decodes checked on every output handshake.
module tb_rv_decode_stage;
  import rv_decode_pkg::*;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [31:0] imm;
    logic [1:0]  fmt;
    logic        ill;
  } exp_t;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  exp_t mon_exp;
  exp_t mon_got;
  int   exp_cnt = 0;
  int   exp_ill = 0;
`ifdef RV_DECODE_STATS_EN
  logic [15:0] stat_count;
  logic [15:0] stat_illegal;
`endif

  rv_decode_stage_if #(.PC_W(32)) bus ();

  rv_decode_stage #(.PC_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef RV_DECODE_STATS_EN
    ,
    .stat_count   (stat_count),
    .stat_illegal (stat_illegal)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [31:0] w, input logic [31:0] pc);
    exp_t e;
    e        = '0;
    e.pc     = pc;
    e.opcode = w[6:0];
    if (w[6:0] == 7'h33) begin
      e.fmt = 2'd0; e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20];
      e.func3 = w[14:12]; e.func7 = w[31:25];
    end else if (w[6:0] == 7'h13 || w[6:0] == 7'h03 || w[6:0] == 7'h67) begin
      e.fmt = 2'd1; e.rd = w[11:7]; e.rs1 = w[19:15]; e.func3 = w[14:12];
      e.imm = {{20{w[31]}}, w[31:20]};
    end else if (w[6:0] == 7'h37 || w[6:0] == 7'h17) begin
      e.fmt = 2'd2; e.rd = w[11:7]; e.rs1 = w[19:15];
      e.imm = {w[31:12], 12'h000};
    end else begin
      e.fmt = 2'd3; e.ill = 1'b1;
    end
    return e;
  endfunction

  // Outputs are sampled on the falling edge; pops precede pushes since the output is registered.
  always @(negedge clk) begin
    if (rst) begin
      exp_cnt = 0;
      exp_ill = 0;
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        total++;
        assert (sb.size() != 0) else begin
          bad++;
          $error("FAIL unexpected_out got_pc=%h exp=<none>", bus.out_pc);
        end
        if (sb.size() != 0) begin
          mon_exp = sb.pop_front();
          mon_got = {bus.out_pc, bus.out_opcode, bus.out_rd, bus.out_rs1, bus.out_rs2,
                     bus.out_func3, bus.out_func7, bus.out_imm, 2'(bus.out_fmt), bus.out_illegal};
          total++;
          assert (mon_got === mon_exp) else begin
            bad++;
            $error("FAIL scoreboard got=%h exp=%h", mon_got, mon_exp);
          end
        end
        if (exp_cnt < 65535) exp_cnt++;
        if (bus.out_illegal && exp_ill < 65535) exp_ill++;
      end
      if (bus.in_valid && bus.in_ready) sb.push_back(model(bus.in_instr, bus.in_pc));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [31:0] instr, input logic [31:0] pc);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    bus.in_pc    = pc;
    while (!bus.in_ready && n < 50) begin
      cyc();
      n++;
    end
    chk("send_timeout", 32'(bus.in_ready), 32'd1);
    cyc();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      cyc();
      n++;
    end
    chk("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_pc     = '0;
    bus.out_ready = 1'b0;
    cyc(); cyc();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_imm", bus.out_imm, 32'd0);
    chk("rst_out_pc", bus.out_pc, 32'd0);
    chk("rst_out_opcode", 32'(bus.out_opcode), 32'd0);
    rst = 1'b0;
    cyc();
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // LUI, one-cycle latency
    bus.out_ready = 1'b1;
    send(32'h0AA01EB7, 32'h100);
    chk("lui_valid", 32'(bus.out_valid), 32'd1);
    chk("lui_opcode", 32'(bus.out_opcode), 32'h37);
    chk("lui_rd", 32'(bus.out_rd), 32'd29);
    chk("lui_imm", bus.out_imm, 32'h0AA01000);
    chk("lui_fmt", 32'(bus.out_fmt), 32'd2);
    chk("lui_illegal", 32'(bus.out_illegal), 32'd0);
    chk("lui_pc", bus.out_pc, 32'h100);
    cyc();

    // I then R back to back
    bus.in_valid = 1'b1; bus.in_instr = 32'hFFF00093; bus.in_pc = 32'h200;
    cyc();
    bus.in_instr = 32'h002081B3; bus.in_pc = 32'h204;
    chk("stream_in_ready0", 32'(bus.in_ready), 32'd1);
    chk("addi_fmt", 32'(bus.out_fmt), 32'd1);
    chk("addi_rd", 32'(bus.out_rd), 32'd1);
    chk("addi_imm", bus.out_imm, 32'hFFFFFFFF);
    cyc();
    bus.in_valid = 1'b0;
    chk("stream_in_ready1", 32'(bus.in_ready), 32'd1);
    chk("add_fmt", 32'(bus.out_fmt), 32'd0);
    chk("add_rd", 32'(bus.out_rd), 32'd3);
    chk("add_rs1", 32'(bus.out_rs1), 32'd1);
    chk("add_rs2", 32'(bus.out_rs2), 32'd2);
    chk("add_imm", bus.out_imm, 32'd0);
    drain();

    // Backpressure: A, B accepted, C held
    bus.out_ready = 1'b0;
    send(32'h00500113, 32'h300);
    send(32'h40208233, 32'h304);
    chk("bp_in_ready_full", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b1; bus.in_instr = 32'h12345537; bus.in_pc = 32'h308;
    cyc(); cyc();
    chk("bp_hold_ready", 32'(bus.in_ready), 32'd0);
    chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_hold_pc", bus.out_pc, 32'h300);
    chk("bp_hold_imm", bus.out_imm, 32'd5);
    bus.out_ready = 1'b1;
    send(32'h12345537, 32'h308);
    drain();
    chk("bp_empty", 32'(bus.out_valid), 32'd0);

    // Illegal opcodes
    send(32'h0000007F, 32'h400);
    chk("ill_fmt", 32'(bus.out_fmt), 32'd3);
    chk("ill_flag", 32'(bus.out_illegal), 32'd1);
    chk("ill_opcode", 32'(bus.out_opcode), 32'h7F);
    chk("ill_imm", bus.out_imm, 32'd0);
    chk("ill_regs", {17'd0, bus.out_rd, bus.out_rs1, bus.out_rs2}, 32'd0);
    send(32'h00000000, 32'h404);
    chk("zero_illegal", 32'(bus.out_illegal), 32'd1);
    drain();

    // Reset while both entries are occupied
    bus.out_ready = 1'b0;
    send(32'h00108093, 32'h500);
    send(32'hFFF00093, 32'h504);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    sb.delete();
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    cyc();
    chk("midrst_in_ready_back", 32'(bus.in_ready), 32'd1);
    chk("midrst_still_empty", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b1;
    send(32'h00A00513, 32'h600);
    drain();
    repeat (3) cyc();

`ifdef RV_DECODE_STATS_EN
    chk("stat_count", 32'(stat_count), 32'(exp_cnt));
    chk("stat_illegal", 32'(stat_illegal), 32'(exp_ill));
    send(32'h0000007F, 32'h700);
    send(32'h00000013, 32'h704);
    bus.out_ready = 1'b0;
    send(32'h00000013, 32'h708);
    repeat (4) cyc();
    chk("stat_stall_nocount", 32'(stat_count), 32'(exp_cnt));
    bus.out_ready = 1'b1;
    drain();
    bus.in_valid = 1'b1; bus.in_instr = 32'h00000013; bus.in_pc = 32'h800;
    repeat (65540) cyc();
    bus.in_valid = 1'b0;
    drain();
    chk("stat_sat", 32'(stat_count), 32'hFFFF);
    chk("stat_sat_model", 32'(stat_count), 32'(exp_cnt));
    chk("stat_illegal_final", 32'(stat_illegal), 32'(exp_ill));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv_decode_stage.md
Name: rv_decode_stage

Overview:
- Pipelined RV32 decode stage: consumes one fetched 32-bit instruction word per handshake and overlays it with the packed instruction_t union (R/I/U views).
- Produces registered decoded fields, a sign-extended immediate, a format code and an illegal flag for the execute stage.
- Valid/ready on both sides.
- 2-entry elastic buffer (output register plus skid register) gives full throughput with a registered in_ready.

Parameters:
- PC_W, 32, width of the program counter carried alongside each instruction.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous active-high
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept; registered (= !skid_valid && !rst_q)
- in_instr  in  32  raw instruction word, interpreted as instruction_t
- in_pc  in  PC_W  PC of in_instr
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  downstream accepts
- out_pc  out  PC_W  PC of decoded instruction
- out_opcode  out  7  opcode field
- out_rd / out_rs1 / out_rs2  out  5 each  register addresses (from R view; rs2 = 0 unless fmt R)
- out_func3  out  3  func3 (0 for U)
- out_func7  out  7  func7 (0 unless fmt R)
- out_imm  out  32  immediate
- out_fmt  out  2  FMT_R=0, FMT_I=1, FMT_U=2, FMT_X=3
- out_illegal  out  1  unsupported/illegal opcode

Behaviour:
- Reset:
  - All state clears while rst=1.
  - out_valid=0, skid empty, all data outputs 0.
  - in_ready=0 while rst=1; in_ready=1 the first cycle after rst falls.
- Format decode on instruction_t:
  - R: opcode 0110011.
  - I: opcode 0010011, 0000011 or 1100111.
  - U: opcode 0110111 or 0010111.
  - X: anything else, including opcode[1:0]!=2'b11.
- Immediate:
  - I: imm[11:0] sign-extended to 32.
  - U: {imm[19:0], 12'h000}.
  - R and X: 0.
- FMT_X: out_illegal=1, rd/rs1/rs2/func3/func7/imm forced 0; opcode and pc passed through.
- Latency:
  - Data accepted at edge N appears with out_valid=1 after edge N.
  - Throughput 1 instruction/cycle while out_ready=1.
- Handshakes: a transfer occurs on any edge where valid && ready.
  - Once out_valid=1, out_valid and all out_* stay stable until out_ready=1.
  - The upstream side obeys the same rule.
- Buffer states: EMPTY, ONE (output reg valid), TWO (output + skid valid).
  - EMPTY + in handshake -> ONE.
  - ONE + in handshake + out stall -> TWO (new entry goes to skid).
  - ONE + in + out handshake -> ONE (output reg reloaded).
  - ONE + out only -> EMPTY.
  - TWO + out handshake -> ONE (skid moves to output reg; in_ready=1 next cycle).
  - TWO: in_ready=0; no input accepted.
- Ordering: strictly FIFO; no entry dropped or duplicated.
- Reset mid-operation: rst=1 discards both entries immediately; out_valid=0 the cycle after.

Optional Feature:
- Macro RV_DECODE_STATS_EN.
- When defined, two extra output ports:
  - stat_count [15:0]: increments on each out handshake.
  - stat_illegal [15:0]: increments on out handshakes with out_illegal=1.
  - Both saturate at 16'hFFFF and clear on rst.
- When undefined, the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package rv_decode_pkg holds:
  - reg_addr_t (5b) and opcode_t (7b).
  - Packed structs R_t, I_t, U_t and packed union instruction_t.
  - fmt_t enum.
  - Opcode localparams OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_LUI, OPC_AUIPC.
  - Packed struct decoded_t bundling all out_* fields except pc.
- Sub-module rv_decode_fields: purely combinational instruction_t -> decoded_t. Instantiated once on the input path; both buffer registers store decoded_t + pc.

Test Plan:
- LUI: in_instr=32'h0AA01EB7, pc=32'h100, out_ready=1 -> next cycle out_valid=1, out_opcode=7'h37, out_rd=29, out_imm=32'h0AA01000, out_fmt=FMT_U, out_illegal=0, out_pc=32'h100.
- I/R stream: back-to-back 32'hFFF00093 (addi x1,x0,-1) then 32'h002081B3 (add x3,x1,x2), out_ready=1.
  - Expected outputs on consecutive cycles: {FMT_I, rd=1, rs1=0, imm=32'hFFFFFFFF}, then {FMT_R, rd=3, rs1=1, rs2=2, func3=0, func7=0, imm=0}.
  - in_ready stays 1 throughout.
- Backpressure: hold out_ready=0 and offer 3 instructions A, B, C.
  - A and B are accepted; in_ready=0 from the cycle after B is accepted; C is held.
  - out_* remain equal to A while stalled.
  - Releasing out_ready yields A, B, C in order with no gaps beyond one cycle.
- Illegal: in_instr=32'h0000007F -> out_fmt=FMT_X, out_illegal=1, out_opcode=7'h7F, imm/rd/rs1/rs2=0; also 32'h00000000 -> illegal.
- Reset mid-operation: fill to TWO, assert rst for 1 cycle -> next cycle out_valid=0, in_ready=0; the following cycle in_ready=1; no stale entry ever emitted.
- Stats (RV_DECODE_STATS_EN): 5 legal + 2 illegal handshakes -> stat_count=7, stat_illegal=2; stalled cycles do not count; preload near 16'hFFFF, further handshakes -> holds 16'hFFFF.
